// File: rtl/dma_stride_engine.sv
// dma_stride_engine: moves 2-D strided tiles between AXI4 memory and a word-addressed scratchpad.
// One burst is outstanding at a time; bursts are clipped to MAX_BURST_LEN and never cross a row.
module dma_stride_engine #(
  parameter int DATA_WIDTH    = 256,
  parameter int ADDR_WIDTH    = 32,
  parameter int SP_ADDR_WIDTH = 14,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_dir,
  input  logic [ADDR_WIDTH-1:0]    cmd_mem_addr,
  input  logic [SP_ADDR_WIDTH-1:0] cmd_sp_addr,
  input  logic [LEN_WIDTH-1:0]     cmd_row_len,
  input  logic [LEN_WIDTH-1:0]     cmd_num_rows,
  input  logic [ADDR_WIDTH-1:0]    cmd_mem_stride,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     arvalid,
  output logic [ADDR_WIDTH-1:0]    araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  input  logic                     arready,
  input  logic                     rvalid,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  output logic                     rready,
  output logic                     awvalid,
  output logic [ADDR_WIDTH-1:0]    awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  input  logic                     awready,
  output logic                     wvalid,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic                     wlast,
  input  logic                     wready,
  input  logic                     bvalid,
  input  logic [1:0]               bresp,
  output logic                     bready,
  output logic                     sp_wr_en,
  output logic [SP_ADDR_WIDTH-1:0] sp_wr_addr,
  output logic [DATA_WIDTH-1:0]    sp_wr_data,
  input  logic                     sp_wr_ready,
  output logic                     sp_rd_en,
  output logic [SP_ADDR_WIDTH-1:0] sp_rd_addr,
  input  logic [DATA_WIDTH-1:0]    sp_rd_data
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_BURST_LEN);

  // state    | meaning
  // IDLE     | waiting for a command, cmd_ready high
  // RD_ADDR  | read burst address offered on AR
  // RD_DATA  | read beats forwarded to the scratchpad write port
  // WR_ADDR  | write burst address offered on AW
  // WR_FETCH | scratchpad read issued for the next beat
  // WR_LATCH | scratchpad data captured into the wdata register
  // WR_DATA  | beat offered on W
  // WR_RESP  | waiting for the burst's B response
  // FINISH   | one-cycle done pulse
  typedef enum logic [3:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_FETCH, WR_LATCH, WR_DATA, WR_RESP, FINISH
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    row_base_q, row_base_d, addr_q, addr_d, stride_q, stride_d;
  logic [SP_ADDR_WIDTH-1:0] sp_ptr_q, sp_ptr_d;
  logic [LEN_WIDTH-1:0]     row_len_q, row_len_d, row_left_q, row_left_d;
  logic [LEN_WIDTH-1:0]     rows_left_q, rows_left_d, beat_q, beat_d;
  logic [7:0]               blen_m1_q, blen_m1_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     error_q, error_d;

  logic                     last_beat, burst_end;
  logic [LEN_WIDTH-1:0]     left_after;
  logic [ADDR_WIDTH-1:0]    burst_bytes;

  function automatic logic [7:0] blen_m1(input logic [LEN_WIDTH-1:0] left);
    logic [LEN_WIDTH-1:0] l;
    l = (left > MAX_L) ? MAX_L : left;
    return 8'(l - LEN_WIDTH'(1));
  endfunction

  assign last_beat   = (beat_q == LEN_WIDTH'(blen_m1_q));
  assign left_after  = row_left_q - (LEN_WIDTH'(blen_m1_q) + LEN_WIDTH'(1));
  assign burst_bytes = (ADDR_WIDTH'(blen_m1_q) + ADDR_WIDTH'(1)) << SIZE;

  always_comb begin
    state_d     = state_q;
    row_base_d  = row_base_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    sp_ptr_d    = sp_ptr_q;
    row_len_d   = row_len_q;
    row_left_d  = row_left_q;
    rows_left_d = rows_left_q;
    beat_d      = beat_q;
    blen_m1_d   = blen_m1_q;
    wdata_d     = wdata_q;
    error_d     = error_q;
    burst_end   = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        row_base_d  = cmd_mem_addr;
        addr_d      = cmd_mem_addr;
        stride_d    = cmd_mem_stride;
        sp_ptr_d    = cmd_sp_addr;
        row_len_d   = cmd_row_len;
        row_left_d  = cmd_row_len;
        rows_left_d = cmd_num_rows;
        blen_m1_d   = blen_m1(cmd_row_len);
        error_d     = 1'b0;
        if (cmd_row_len == '0 || cmd_num_rows == '0) state_d = FINISH;
        else if (cmd_dir)                            state_d = WR_ADDR;
        else                                         state_d = RD_ADDR;
      end
      RD_ADDR: if (arready) begin
        beat_d  = '0;
        state_d = RD_DATA;
      end
      RD_DATA: if (rvalid && sp_wr_ready) begin
        sp_ptr_d = sp_ptr_q + SP_ADDR_WIDTH'(1);
        beat_d   = beat_q + LEN_WIDTH'(1);
        if (rresp != 2'b00 || rlast != last_beat) error_d = 1'b1;
        burst_end = last_beat;
      end
      WR_ADDR: if (awready) begin
        beat_d  = '0;
        state_d = WR_FETCH;
      end
      WR_FETCH: state_d = WR_LATCH;
      WR_LATCH: begin
        wdata_d  = sp_rd_data;
        sp_ptr_d = sp_ptr_q + SP_ADDR_WIDTH'(1);
        state_d  = WR_DATA;
      end
      WR_DATA: if (wready) begin
        beat_d  = beat_q + LEN_WIDTH'(1);
        state_d = last_beat ? WR_RESP : WR_FETCH;
      end
      WR_RESP: if (bvalid) begin
        if (bresp != 2'b00) error_d = 1'b1;
        burst_end = 1'b1;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pick the next burst: rest of this row, first burst of the next row, or done.
    if (burst_end) begin
      if (left_after != '0) begin
        addr_d     = addr_q + burst_bytes;
        row_left_d = left_after;
        blen_m1_d  = blen_m1(left_after);
        state_d    = (state_q == RD_DATA) ? RD_ADDR : WR_ADDR;
      end else if (rows_left_q == LEN_WIDTH'(1)) begin
        state_d = FINISH;
      end else begin
        rows_left_d = rows_left_q - LEN_WIDTH'(1);
        row_base_d  = row_base_q + stride_q;
        addr_d      = row_base_q + stride_q;
        row_left_d  = row_len_q;
        blen_m1_d   = blen_m1(row_len_q);
        state_d     = (state_q == RD_DATA) ? RD_ADDR : WR_ADDR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_base_q  <= '0;
      addr_q      <= '0;
      stride_q    <= '0;
      sp_ptr_q    <= '0;
      row_len_q   <= '0;
      row_left_q  <= '0;
      rows_left_q <= '0;
      beat_q      <= '0;
      blen_m1_q   <= '0;
      wdata_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_base_q  <= row_base_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      sp_ptr_q    <= sp_ptr_d;
      row_len_q   <= row_len_d;
      row_left_q  <= row_left_d;
      rows_left_q <= rows_left_d;
      beat_q      <= beat_d;
      blen_m1_q   <= blen_m1_d;
      wdata_q     <= wdata_d;
      error_q     <= error_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign error      = error_q;
  assign arvalid    = (state_q == RD_ADDR);
  assign araddr     = addr_q;
  assign arlen      = blen_m1_q;
  assign arsize     = 3'(SIZE);
  assign rready     = (state_q == RD_DATA) && sp_wr_ready;
  assign sp_wr_en   = rready && rvalid;
  assign sp_wr_addr = sp_ptr_q;
  assign sp_wr_data = (state_q == RD_DATA) ? rdata : '0;
  assign awvalid    = (state_q == WR_ADDR);
  assign awaddr     = addr_q;
  assign awlen      = blen_m1_q;
  assign awsize     = 3'(SIZE);
  assign sp_rd_en   = (state_q == WR_FETCH);
  assign sp_rd_addr = sp_ptr_q;
  assign wvalid     = (state_q == WR_DATA);
  assign wdata      = wdata_q;
  assign wlast      = (state_q == WR_DATA) && last_beat;
  assign bready     = (state_q == WR_RESP);
endmodule

// File: tb/tb_dma_stride_engine.sv
// Randomized bench for dma_stride_engine: AXI/scratchpad responders plus a tile-level model
// that lists the expected bursts and beats of each command.
module tb_dma_stride_engine;
  localparam int DW = 256, AW = 32, SPW = 14, MB = 16, LW = 16, BY = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           cmd_valid = 1'b0, cmd_dir = 1'b0;
  logic [AW-1:0]  cmd_mem_addr = '0, cmd_mem_stride = '0;
  logic [SPW-1:0] cmd_sp_addr = '0;
  logic [LW-1:0]  cmd_row_len = '0, cmd_num_rows = '0;
  logic           cmd_ready, busy, done, error;
  logic           arvalid, rready, awvalid, wvalid, wlast, bready, sp_wr_en, sp_rd_en;
  logic [AW-1:0]  araddr, awaddr;
  logic [7:0]     arlen, awlen;
  logic [2:0]     arsize, awsize;
  logic [DW-1:0]  wdata, sp_wr_data;
  logic [SPW-1:0] sp_wr_addr, sp_rd_addr;
  logic           arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, awready = 1'b0, wready = 1'b0;
  logic           bvalid = 1'b0, sp_wr_ready = 1'b0;
  logic [1:0]     rresp = '0, bresp = '0;
  logic [DW-1:0]  rdata = '0, sp_rd_data = '0;

  dma_stride_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SP_ADDR_WIDTH(SPW),
                      .MAX_BURST_LEN(MB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_mem_addr(cmd_mem_addr), .cmd_sp_addr(cmd_sp_addr), .cmd_row_len(cmd_row_len),
    .cmd_num_rows(cmd_num_rows), .cmd_mem_stride(cmd_mem_stride), .busy(busy), .done(done),
    .error(error), .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arready(arready), .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rready(rready), .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awready(awready), .wvalid(wvalid), .wdata(wdata), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready), .sp_wr_en(sp_wr_en),
    .sp_wr_addr(sp_wr_addr), .sp_wr_data(sp_wr_data), .sp_wr_ready(sp_wr_ready),
    .sp_rd_en(sp_rd_en), .sp_rd_addr(sp_rd_addr), .sp_rd_data(sp_rd_data));

  int n_checks = 0, n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] memdata(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = a ^ (32'(i) * 32'h1111_1111) ^ 32'hC0DE_0000;
    return r;
  endfunction

  function automatic logic [DW-1:0] spdata(input logic [SPW-1:0] s);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = (32'(s) * 32'h9E37_79B9) ^ (32'(i) << 24);
    return r;
  endfunction

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } burst_t;
  typedef struct packed { logic [SPW-1:0] sp; logic [AW-1:0] mem; logic last; } beat_t;
  burst_t exp_bq[$];
  beat_t  exp_tq[$];
  logic [AW-1:0]  obs_ar[$], obs_aw[$];
  logic [7:0]     obs_arlen[$], obs_awlen[$];
  logic [SPW-1:0] obs_sp[$];
  int wlast_cnt = 0, b_cnt = 0, done_cnt = 0;

  // Tile model: row r at mem + r*stride, chunks of at most MB words, scratchpad contiguous.
  task automatic build_model(input logic [AW-1:0] mem, input logic [SPW-1:0] sp,
                             input int rl, input int nr, input logic [AW-1:0] stride);
    logic [SPW-1:0] spp;
    logic [AW-1:0]  rowa;
    int L;
    exp_bq.delete();
    exp_tq.delete();
    spp = sp;
    for (int r = 0; r < nr; r++) begin
      rowa = mem + AW'(r) * stride;
      for (int off = 0; off < rl; off += MB) begin
        L = (rl - off < MB) ? rl - off : MB;
        exp_bq.push_back('{addr: rowa + AW'(off * BY), len: 8'(L - 1)});
        for (int b = 0; b < L; b++) begin
          exp_tq.push_back('{sp: spp, mem: rowa + AW'((off + b) * BY), last: (b == L - 1)});
          spp = spp + SPW'(1);
        end
      end
    end
  endtask

  logic bp = 1'b0, flush = 1'b0, tog = 1'b0, cur_dir = 1'b0, exp_error = 1'b0;
  int inj_rresp_beat = -1, inj_rlast_beat = -1, inj_bresp_burst = -1;
  int rbeat_idx = 0, b_idx = 0, r_left = 0, b_pend = 0, ar_wait = 0, aw_wait = 0;
  logic [AW-1:0] r_addr = '0, prev_addr = '0;
  logic [7:0] prev_len = '0;
  logic [DW-1:0] prev_wdata = '0;
  logic prev_wlast = 1'b0, ar_stall = 1'b0, aw_stall = 1'b0, w_stall = 1'b0;
  logic r_hold = 1'b0, b_hold = 1'b0, sp_pend = 1'b0;
  logic [SPW-1:0] sp_pend_a = '0;

  always @(negedge clk) begin
    sp_rd_data = sp_pend ? spdata(sp_pend_a) : {8{$urandom()}};
    sp_pend    = sp_rd_en;
    sp_pend_a  = sp_rd_addr;
    if (rst || flush) begin
      arready = 0; rvalid = 0; rresp = 0; rlast = 0; rdata = '0; awready = 0; wready = 0;
      bvalid = 0; bresp = 0; sp_wr_ready = 0;
      r_left = 0; b_pend = 0; ar_wait = 0; aw_wait = 0;
      ar_stall = 0; aw_stall = 0; w_stall = 0; r_hold = 0; b_hold = 0;
    end else begin
      tog = ~tog;
      ar_wait = arvalid ? ar_wait + 1 : 0;
      aw_wait = awvalid ? aw_wait + 1 : 0;
      arready = bp ? (ar_wait > 5) : 1'($urandom_range(0, 1));
      awready = bp ? (aw_wait > 5) : 1'($urandom_range(0, 1));
      sp_wr_ready = bp ? tog : ($urandom_range(0, 3) != 0);
      wready      = bp ? tog : ($urandom_range(0, 3) != 0);
      if (r_left > 0) begin
        rvalid = r_hold || bp || ($urandom_range(0, 3) != 0);
        rdata  = memdata(r_addr);
        rlast  = (r_left == 1) ^ (rbeat_idx == inj_rlast_beat);
        rresp  = (rbeat_idx == inj_rresp_beat) ? 2'd2 : 2'd0;
      end else begin
        rvalid = 0; rlast = 0; rresp = 0; rdata = {8{$urandom()}};
      end
      bvalid = (b_pend > 0) && (b_hold || ($urandom_range(0, 2) != 0));
      bresp  = (bvalid && b_idx == inj_bresp_burst) ? 2'd2 : 2'd0;
      #1;
      // read address channel
      if (ar_stall) begin
        chk("ar_hold_valid", DW'(arvalid), 1);
        chk("ar_hold_addr", DW'(araddr), DW'(prev_addr));
        chk("ar_hold_len", DW'(arlen), DW'(prev_len));
      end
      if (aw_stall) begin
        chk("aw_hold_valid", DW'(awvalid), 1);
        chk("aw_hold_addr", DW'(awaddr), DW'(prev_addr));
        chk("aw_hold_len", DW'(awlen), DW'(prev_len));
      end
      ar_stall = arvalid && !arready;
      aw_stall = awvalid && !awready;
      if (arvalid) begin prev_addr = araddr; prev_len = arlen; end
      if (awvalid) begin prev_addr = awaddr; prev_len = awlen; end
      if (arvalid && arready) begin
        chk("ar_dir", DW'(cur_dir), 0);
        chk("ar_expected", DW'(exp_bq.size() > 0), 1);
        if (exp_bq.size() > 0) begin
          chk("araddr", DW'(araddr), DW'(exp_bq[0].addr));
          chk("arlen", DW'(arlen), DW'(exp_bq[0].len));
          void'(exp_bq.pop_front());
        end
        obs_ar.push_back(araddr);
        obs_arlen.push_back(arlen);
        r_left = int'(arlen) + 1;
        r_addr = araddr;
      end
      // read data -> scratchpad write
      if (rvalid) chk("rready", DW'(rready), DW'(sp_wr_ready));
      chk("sp_wr_en", DW'(sp_wr_en), DW'(rvalid && sp_wr_ready));
      if (rvalid && sp_wr_ready) begin
        chk("rd_beat_expected", DW'(exp_tq.size() > 0), 1);
        if (exp_tq.size() > 0) begin
          chk("sp_wr_addr", DW'(sp_wr_addr), DW'(exp_tq[0].sp));
          chk("sp_wr_data", sp_wr_data, memdata(exp_tq[0].mem));
          if (rresp != 2'd0 || rlast != exp_tq[0].last) exp_error = 1'b1;
          void'(exp_tq.pop_front());
        end
        obs_sp.push_back(sp_wr_addr);
        r_left--;
        r_addr = r_addr + AW'(BY);
        rbeat_idx++;
        r_hold = 0;
      end else r_hold = rvalid;
      // write address channel
      if (awvalid && awready) begin
        chk("aw_dir", DW'(cur_dir), 1);
        chk("aw_expected", DW'(exp_bq.size() > 0), 1);
        if (exp_bq.size() > 0) begin
          chk("awaddr", DW'(awaddr), DW'(exp_bq[0].addr));
          chk("awlen", DW'(awlen), DW'(exp_bq[0].len));
          void'(exp_bq.pop_front());
        end
        obs_aw.push_back(awaddr);
        obs_awlen.push_back(awlen);
      end
      // write data channel
      if (w_stall) begin
        chk("w_hold_valid", DW'(wvalid), 1);
        chk("w_hold_data", wdata, prev_wdata);
        chk("w_hold_last", DW'(wlast), DW'(prev_wlast));
      end
      w_stall = wvalid && !wready;
      prev_wdata = wdata;
      prev_wlast = wlast;
      if (wvalid && wready) begin
        chk("wr_beat_expected", DW'(exp_tq.size() > 0), 1);
        if (exp_tq.size() > 0) begin
          chk("wdata", wdata, spdata(exp_tq[0].sp));
          chk("wlast", DW'(wlast), DW'(exp_tq[0].last));
          if (exp_tq[0].last) b_pend++;
          void'(exp_tq.pop_front());
        end
        if (wlast) wlast_cnt++;
      end
      // write response channel
      if (bready) chk("bready_pending", DW'(b_pend > 0), 1);
      if (bvalid) chk("bready", DW'(bready), 1);
      if (bvalid && bready) begin
        if (bresp != 2'd0) exp_error = 1'b1;
        b_pend--; b_idx++; b_cnt++; b_hold = 0;
      end else b_hold = bvalid;
      if (done) begin
        done_cnt++;
        chk("done_bursts_left", DW'(exp_bq.size()), 0);
        chk("done_beats_left", DW'(exp_tq.size()), 0);
        chk("done_outstanding", DW'(r_left + b_pend), 0);
        chk("error_at_done", DW'(error), DW'(exp_error));
      end
    end
  end

  task automatic start_cmd(input logic dir, input logic [AW-1:0] mem, input logic [SPW-1:0] sp,
                           input int rl, input int nr, input logic [AW-1:0] stride);
    build_model(mem, sp, rl, nr, stride);
    obs_ar.delete(); obs_arlen.delete(); obs_aw.delete(); obs_awlen.delete(); obs_sp.delete();
    wlast_cnt = 0; b_cnt = 0; rbeat_idx = 0; b_idx = 0;
    @(negedge clk);
    cmd_dir = dir; cmd_mem_addr = mem; cmd_sp_addr = sp; cmd_row_len = LW'(rl);
    cmd_num_rows = LW'(nr); cmd_mem_stride = stride; cmd_valid = 1'b1;
    cur_dir = dir; exp_error = 1'b0;
    #2 chk("cmd_ready", DW'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2 chk("busy_after_accept", DW'(busy), 1);
    chk("error_cleared", DW'(error), 0);
    if (rl == 0 || nr == 0) chk("zero_len_done", DW'(done), 1);
  endtask

  task automatic run_cmd(input logic dir, input logic [AW-1:0] mem, input logic [SPW-1:0] sp,
                         input int rl, input int nr, input logic [AW-1:0] stride);
    int start, cnt;
    start = done_cnt;
    start_cmd(dir, mem, sp, rl, nr, stride);
    cnt = 0;
    while (done_cnt == start && cnt < 5000) begin @(negedge clk); #2; cnt++; end
    chk("done_seen", DW'(done_cnt != start), 1);
    @(negedge clk); #2;
    chk("done_single", DW'(done), 0);
    chk("ready_again", DW'(cmd_ready), 1);
    chk("done_count", DW'(done_cnt - start), 1);
  endtask

  initial begin
    int cnt, dc, rl, nr;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", DW'(busy), 0);             chk("rst_done", DW'(done), 0);
    chk("rst_error", DW'(error), 0);           chk("rst_arvalid", DW'(arvalid), 0);
    chk("rst_awvalid", DW'(awvalid), 0);       chk("rst_wvalid", DW'(wvalid), 0);
    chk("rst_bready", DW'(bready), 0);         chk("rst_sp_rd_en", DW'(sp_rd_en), 0);
    chk("rst_araddr", DW'(araddr), 0);         chk("rst_arlen", DW'(arlen), 0);
    chk("rst_wdata", wdata, 0);                chk("rst_wlast", DW'(wlast), 0);
    chk("rst_arsize", DW'(arsize), 5);         chk("rst_awsize", DW'(awsize), 5);
    rst = 1'b0;
    @(negedge clk); #2 chk("ready_after_rst", DW'(cmd_ready), 1);

    // burst split
    run_cmd(1'b0, 32'h1000, 14'h10, 20, 1, 32'h0);
    chk("split_ar_cnt", DW'(obs_ar.size()), 2);
    if (obs_ar.size() == 2) begin
      chk("split_ar0", DW'(obs_ar[0]), 32'h1000); chk("split_len0", DW'(obs_arlen[0]), 15);
      chk("split_ar1", DW'(obs_ar[1]), 32'h1200); chk("split_len1", DW'(obs_arlen[1]), 3);
    end
    chk("split_sp_cnt", DW'(obs_sp.size()), 20);
    if (obs_sp.size() == 20) begin
      chk("split_sp_first", DW'(obs_sp[0]), 14'h10); chk("split_sp_last", DW'(obs_sp[19]), 14'h23);
    end

    // 2-D read with scratchpad wrap
    run_cmd(1'b0, 32'h1000, 14'h3FFE, 4, 3, 32'h1000);
    chk("rd2d_ar_cnt", DW'(obs_ar.size()), 3);
    if (obs_ar.size() == 3) begin
      chk("rd2d_ar0", DW'(obs_ar[0]), 32'h1000); chk("rd2d_ar1", DW'(obs_ar[1]), 32'h2000);
      chk("rd2d_ar2", DW'(obs_ar[2]), 32'h3000); chk("rd2d_len", DW'(obs_arlen[2]), 3);
    end
    if (obs_sp.size() == 12) begin
      chk("rd2d_sp1", DW'(obs_sp[1]), 14'h3FFF); chk("rd2d_sp2", DW'(obs_sp[2]), 14'h0);
      chk("rd2d_sp11", DW'(obs_sp[11]), 14'h9);
    end else chk("rd2d_sp_cnt", DW'(obs_sp.size()), 12);

    // 2-D write
    run_cmd(1'b1, 32'h0, 14'h100, 2, 2, 32'h80);
    chk("wr2d_aw_cnt", DW'(obs_aw.size()), 2);
    if (obs_aw.size() == 2) begin
      chk("wr2d_aw0", DW'(obs_aw[0]), 32'h0);  chk("wr2d_aw1", DW'(obs_aw[1]), 32'h80);
      chk("wr2d_len", DW'(obs_awlen[1]), 1);
    end
    chk("wr2d_wlast_cnt", DW'(wlast_cnt), 2);
    chk("wr2d_b_cnt", DW'(b_cnt), 2);

    // backpressure
    bp = 1'b1;
    run_cmd(1'b0, 32'h4000, 14'h200, 20, 2, 32'h400);
    run_cmd(1'b1, 32'h8000, 14'h300, 5, 2, 32'h100);
    bp = 1'b0;

    // errors
    inj_bresp_burst = 0;
    run_cmd(1'b1, 32'h0, 14'h40, 2, 2, 32'h80);
    chk("err_second_burst", DW'(obs_aw.size()), 2);
    chk("err_sticky", DW'(error), 1);
    inj_bresp_burst = -1;
    inj_rresp_beat = 2;
    run_cmd(1'b0, 32'h2000, 14'h0, 3, 1, 32'h0);
    chk("rresp_err_sticky", DW'(error), 1);
    inj_rresp_beat = -1;
    inj_rlast_beat = 1;
    run_cmd(1'b0, 32'h2000, 14'h0, 4, 1, 32'h0);
    chk("rlast_err_sticky", DW'(error), 1);
    inj_rlast_beat = -1;

    // zero length
    run_cmd(1'b0, 32'h1000, 14'h0, 0, 3, 32'h40);
    chk("zero_no_ar", DW'(obs_ar.size()), 0);
    run_cmd(1'b1, 32'h1000, 14'h0, 5, 0, 32'h40);
    chk("zero_no_aw", DW'(obs_aw.size()), 0);

    // reset in the middle of RD_DATA
    start_cmd(1'b0, 32'h6000, 14'h0, 40, 2, 32'h800);
    cnt = 0;
    while (obs_sp.size() < 3 && cnt < 500) begin @(negedge clk); #2; cnt++; end
    chk("mid_rst_beats_seen", DW'(obs_sp.size() >= 3), 1);
    dc = done_cnt;
    #1 rst = 1'b1; flush = 1'b1;
    @(negedge clk); #3;
    chk("mid_rst_rready", DW'(rready), 0);   chk("mid_rst_busy", DW'(busy), 0);
    chk("mid_rst_done", DW'(done), 0);       chk("mid_rst_sp_wr_en", DW'(sp_wr_en), 0);
    chk("mid_rst_arvalid", DW'(arvalid), 0); chk("mid_rst_ready", DW'(cmd_ready), 1);
    rst = 1'b0;
    exp_bq.delete(); exp_tq.delete();
    flush = 1'b0;
    repeat (5) @(negedge clk);
    #2 chk("mid_rst_no_done", DW'(done_cnt - dc), 0);

    // randomized commands
    for (int k = 0; k < 12; k++) begin
      rl = $urandom_range(0, 40);
      nr = $urandom_range(0, 4);
      bp = ($urandom_range(0, 3) == 0);
      inj_rresp_beat  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
      inj_rlast_beat  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 30) : -1;
      inj_bresp_burst = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      run_cmd(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFE0, SPW'($urandom()),
              rl, nr, $urandom_range(0, 4095) << 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
